// File: rtl/alu_display_sched.sv
// Display scheduler: selects num_1 / num_2 / ALU result (manual or round-robin),
// formats it into display nibbles and offers each changed frame to the display driver.
module alu_display_sched #(
    parameter int unsigned DWELL_CYCLES = 100_000_000,
    parameter int unsigned DWELL_W      = 27
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [7:0]  num_1_i,
    input  logic [7:0]  num_2_i,
    input  logic [15:0] alu_result_i,
    input  logic        auto_i,
    input  logic [2:0]  num_select_i,
    input  logic        upd_ready_i,
    output logic        upd_valid_o,
    output logic [15:0] data_disp_o,
    output logic [1:0]  src_o,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a frame transfers on the rising edge where upd_valid_o and
    // upd_ready_i are both 1; while valid is high data/src are frozen.
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               valid_q, valid_d;
    logic [15:0]        data_q, data_d;
    logic [1:0]         src_q, src_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         rr_q, rr_d;

    logic [1:0]         man_src;
    logic [1:0]         cur_src;
    logic [7:0]         num_sel;
    logic [15:0]        next_data;
    logic               dwell_wrap;

    always_comb begin
        case (num_select_i)
            3'b001:  man_src = 2'd0;
            3'b010:  man_src = 2'd1;
            default: man_src = 2'd2;
        endcase
    end

    assign cur_src = auto_i ? rr_q : man_src;
    assign num_sel = (cur_src == 2'd0) ? num_1_i : num_2_i;

    // Operands occupy the two leftmost digits, least-significant nibble first.
    always_comb begin
        if (cur_src == 2'd2) begin
            next_data = {alu_result_i[3:0], alu_result_i[7:4],
                         alu_result_i[11:8], alu_result_i[15:12]};
        end else begin
            next_data = {num_sel[3:0], num_sel[7:4], 8'h00};
        end
    end

    assign dwell_wrap = (dwell_q == DWELL_W'(DWELL_CYCLES - 1));

    always_comb begin
        dwell_d = dwell_q;
        rr_d    = rr_q;
        if (!auto_i) begin
            dwell_d = '0;
            rr_d    = 2'd0;
        end else if (dwell_wrap) begin
            dwell_d = '0;
            rr_d    = (rr_q == 2'd2) ? 2'd0 : 2'(rr_q + 2'd1);
        end else begin
            dwell_d = DWELL_W'(dwell_q + 1'b1);
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        case (state_q)
            ST_INIT: begin
                data_d  = next_data;
                src_d   = cur_src;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (upd_ready_i) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if ((next_data != data_q) || (cur_src != src_q)) begin
                    data_d  = next_data;
                    src_d   = cur_src;
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        valid_d = (state_d == ST_SEND);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_INIT;
            valid_q <= 1'b0;
            data_q  <= 16'h0000;
            src_q   <= 2'd0;
            dwell_q <= '0;
            rr_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            dwell_q <= dwell_d;
            rr_q    <= rr_d;
        end
    end

    assign upd_valid_o = valid_q;
    assign data_disp_o = data_q;
    assign src_o       = src_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_display_sched.sv
// Bench for alu_display_sched: directed scenarios plus randomized manual traffic,
// with frames scored against an expected queue by a negedge monitor.
module tb_alu_display_sched;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic [7:0]  num_1, num_2;
    logic [15:0] alu_result;
    logic        auto_m;
    logic [2:0]  num_select;
    logic        upd_ready;
    logic        upd_valid;
    logic [15:0] data_disp;
    logic [1:0]  src;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [17:0] exp_q[$];
    int          xfer_cyc[$];
    logic [17:0] last_exp;
    bit          have_last;

    logic        prev_stall;
    logic [17:0] prev_frame;

    alu_display_sched #(.DWELL_CYCLES(4), .DWELL_W(3)) dut (
        .clk_i(clk),
        .reset_ni(reset_ni),
        .num_1_i(num_1),
        .num_2_i(num_2),
        .alu_result_i(alu_result),
        .auto_i(auto_m),
        .num_select_i(num_select),
        .upd_ready_i(upd_ready),
        .upd_valid_o(upd_valid),
        .data_disp_o(data_disp),
        .src_o(src),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: source decode and digit layout as described for the display.
    function automatic logic [1:0] man_src(input logic [2:0] sel);
        if (sel == 3'b001) return 2'd0;
        if (sel == 3'b010) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [15:0] fmt(input logic [1:0] s);
        logic [7:0]  n;
        logic [15:0] r;
        r = alu_result;
        if (s == 2'd2) begin
            return 16'((r % 16) * 4096 + ((r / 16) % 16) * 256 +
                       ((r / 256) % 16) * 16 + (r / 4096));
        end
        n = (s == 2'd0) ? num_1 : num_2;
        return 16'((n % 16) * 4096 + (n / 16) * 256);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [17:0] f);
        exp_q.push_back(f);
        last_exp  = f;
        have_last = 1'b1;
    endtask

    // Manual mode: a frame is due only when source or content differs from the last one sent.
    task automatic expect_manual();
        logic [17:0] f;
        f = {man_src(num_select), fmt(man_src(num_select))};
        if (!have_last || f != last_exp) push_exp(f);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check({name, " drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (!reset_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("valid held under backpressure", {31'd0, upd_valid}, 32'd1);
                check("frame frozen under backpressure", {14'd0, src, data_disp}, {14'd0, prev_frame});
            end
            if (upd_valid && upd_ready) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected frame", {14'd0, src, data_disp}, 32'hFFFF_FFFF);
                end else begin
                    check("frame", {14'd0, src, data_disp}, {14'd0, exp_q.pop_front()});
                end
            end
            prev_stall = upd_valid && !upd_ready;
            prev_frame = {src, data_disp};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        reset_ni   = 1'b0;
        num_1      = 8'hA5;
        num_2      = 8'h00;
        alu_result = 16'h0000;
        auto_m     = 1'b0;
        num_select = 3'b001;
        upd_ready  = 1'b1;
        have_last  = 1'b0;
        repeat (3) tick();
        check("reset valid", {31'd0, upd_valid}, 32'd0);
        check("reset data", {16'd0, data_disp}, 32'h0000);
        check("reset src", {30'd0, src}, 32'd0);

        // Reset release and first frame
        push_exp({2'd0, 16'h5A00});
        reset_ni = 1'b1;
        #1;
        check("valid low during INIT", {31'd0, upd_valid}, 32'd0);
        tick();
        check("valid in 2nd cycle", {31'd0, upd_valid}, 32'd1);
        check("first frame data", {16'd0, data_disp}, 32'h5A00);
        wait_drain("first frame");
        repeat (5) tick();
        check("idle after first frame", {31'd0, upd_valid}, 32'd0);

        // Result formatting, then a multi-hot select that maps to the same source
        alu_result = 16'h1234;
        num_select = 3'b100;
        push_exp({2'd2, 16'h4321});
        wait_drain("result frame");
        num_select = 3'b011;
        expect_manual();
        repeat (6) tick();
        check("no frame for same src/data", {31'd0, upd_valid}, 32'd0);
        check("queue after 011", exp_q.size(), 0);

        // Equal operands still produce a frame on source change
        num_1 = 8'h33;
        num_2 = 8'h33;
        num_select = 3'b001;
        expect_manual();
        wait_drain("equal num_1");
        num_select = 3'b010;
        push_exp({2'd1, 16'h3300});
        wait_drain("equal num_2");

        // Backpressure: pending frame held while num_2 changes three times
        upd_ready = 1'b0;
        num_2 = 8'h11;
        expect_manual();
        tick();
        tick();
        check("pending valid", {31'd0, upd_valid}, 32'd1);
        check("pending data", {16'd0, data_disp}, 32'h1100);
        for (int i = 0; i < 3; i++) begin
            num_2 = 8'(8'h40 + 8'(i * 17) + 8'($urandom_range(0, 15)));
            tick();
            check("frozen data", {16'd0, data_disp}, 32'h1100);
        end
        expect_manual();
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        tick();
        tick();
        check("latest pending valid", {31'd0, upd_valid}, 32'd1);
        check("latest pending data", {16'd0, data_disp}, {16'd0, fmt(2'd1)});
        upd_ready = 1'b1;
        wait_drain("backpressure");

        // Round-robin with a 4-cycle dwell, entered from manual source 2
        num_1 = 8'h12;
        num_2 = 8'h34;
        alu_result = 16'hBEEF;
        num_select = 3'b100;
        expect_manual();
        wait_drain("pre auto");
        xfer_cyc.delete();
        auto_m = 1'b1;
        push_exp({2'd0, fmt(2'd0)});
        push_exp({2'd1, fmt(2'd1)});
        push_exp({2'd2, fmt(2'd2)});
        push_exp({2'd0, fmt(2'd0)});
        repeat (14) tick();
        auto_m = 1'b0;
        expect_manual();
        wait_drain("round robin");
        if (xfer_cyc.size() >= 4) begin
            for (int i = 1; i < 4; i++) check("rr spacing", xfer_cyc[i] - xfer_cyc[i-1], 4);
        end else begin
            check("rr frame count", xfer_cyc.size(), 5);
        end
        auto_m = 1'b1;
        push_exp({2'd0, fmt(2'd0)});
        wait_drain("auto restart");
        auto_m = 1'b0;
        expect_manual();
        wait_drain("auto exit");

        // Randomized manual traffic with random backpressure
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) num_1 = 8'($urandom);
            if ($urandom_range(0, 1) == 1) num_2 = 8'($urandom);
            if ($urandom_range(0, 1) == 1) alu_result = 16'($urandom);
            num_select = 3'($urandom_range(0, 7));
            upd_ready = 1'($urandom_range(0, 1));
            expect_manual();
            repeat ($urandom_range(0, 3)) tick();
            upd_ready = 1'b1;
            wait_drain("random");
            tick();
        end

        // Reset in the middle of a pending handshake
        upd_ready = 1'b0;
        num_select = 3'b001;
        v = num_1 ^ 8'h5A;
        num_1 = v;
        expect_manual();
        tick();
        tick();
        check("pre-reset valid", {31'd0, upd_valid}, 32'd1);
        #2;
        reset_ni = 1'b0;
        #1;
        check("async reset valid", {31'd0, upd_valid}, 32'd0);
        check("async reset data", {16'd0, data_disp}, 32'h0000);
        check("async reset src", {30'd0, src}, 32'd0);
        exp_q.delete();
        have_last = 1'b0;
        tick();
        tick();
        reset_ni = 1'b1;
        upd_ready = 1'b1;
        expect_manual();
        #1;
        check("INIT again valid low", {31'd0, upd_valid}, 32'd0);
        tick();
        check("INIT again valid", {31'd0, upd_valid}, 32'd1);
        wait_drain("post reset");
        repeat (4) tick();

        check("final queue empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
